// File: rtl/nucore_alu_arbiter.sv
// Two-port arbiter in front of the shared NuCore ALU: grant, launch, wait ALU_LAT, return result.
// Optional: define NUCORE_ARB_FIXED_PRIO_EN for fixed priority to port 0 (default is round-robin).
module nucore_alu_arbiter #(
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [OP_W-1:0]   op0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [OP_W-1:0]   op1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags,
    output logic              busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_done0;
    logic              r_done1;
    logic              r_alu_start;
    logic              r_busy;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_result;
    logic [3:0]        r_flags;
    logic              w_any_req;
    logic              w_pick1;

    assign w_any_req = req0 | req1;

`ifdef NUCORE_ARB_FIXED_PRIO_EN
    // Winner select: port 0 always wins, port 1 only when port 0 is quiet.
    always_comb begin
        w_pick1 = ~req0;
    end
`else
    logic r_last_gnt;

    // Winner select: on a tie grant the port that did not win last time.
    always_comb begin
        if (req0 && req1) begin
            w_pick1 = ~r_last_gnt;
        end else begin
            w_pick1 = req1;
        end
    end

    // Round-robin history; starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if ((r_state == ST_IDLE) && w_any_req) begin
            r_last_gnt <= w_pick1;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end
`endif

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_alu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_op    <= '0;
            r_result    <= '0;
            r_flags     <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= ST_ISSUE;
                        r_alu_a     <= w_pick1 ? a1 : a0;
                        r_alu_b     <= w_pick1 ? b1 : b0;
                        r_alu_op    <= w_pick1 ? op1 : op0;
                        r_gnt0      <= ~w_pick1;
                        r_gnt1      <= w_pick1;
                        r_alu_start <= 1'b1;
                        r_busy      <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_alu_start <= 1'b0;
                    r_cnt       <= 4'd0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == LAST_CNT) begin
                        r_result <= alu_result;
                        r_flags  <= alu_flags;
                        r_done0  <= r_gnt0;
                        r_done1  <= r_gnt1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_DONE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_op    = r_alu_op;
    assign alu_start = r_alu_start;
    assign result    = r_result;
    assign flags     = r_flags;
    assign busy      = r_busy;

endmodule

// File: tb/tb_nucore_alu_arbiter.sv
// Bench for nucore_alu_arbiter: two instances (ALU_LAT=1 and 4) driven from shared requester inputs.
module tb_nucore_alu_arbiter;
    localparam int LAT1 = 1;
    localparam int LAT4 = 4;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] a0 = 32'd0, b0 = 32'd0, a1 = 32'd0, b1 = 32'd0;
    logic [3:0]  op0 = 4'd0, op1 = 4'd0;

    logic        gnt0, gnt1, done0, done1, alu_start, busy;
    logic [31:0] alu_a, alu_b, alu_result, result;
    logic [3:0]  alu_op, alu_flags, flags;
    logic        gnt0_l4, gnt1_l4, done0_l4, done1_l4, alu_start_l4, busy_l4;
    logic [31:0] alu_a_l4, alu_b_l4, alu_result_l4, result_l4;
    logic [3:0]  alu_op_l4, alu_flags_l4, flags_l4;

    int n_checks = 0;
    int n_fail = 0;

    nucore_alu_arbiter #(.DATA_W(32), .OP_W(4), .ALU_LAT(LAT1)) u_dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1), .done1(done1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .result(result), .flags(flags), .busy(busy)
    );

    nucore_alu_arbiter #(.DATA_W(32), .OP_W(4), .ALU_LAT(LAT4)) u_dut4 (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .gnt0(gnt0_l4), .done0(done0_l4),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .gnt1(gnt1_l4), .done1(done1_l4),
        .alu_a(alu_a_l4), .alu_b(alu_b_l4), .alu_op(alu_op_l4), .alu_start(alu_start_l4),
        .alu_result(alu_result_l4), .alu_flags(alu_flags_l4),
        .result(result_l4), .flags(flags_l4), .busy(busy_l4)
    );

    // Reference ALU: returns {N,Z,C,V, result}; C on SUB means borrow.
    function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [32:0] w;
        logic [31:0] r;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    // ALU stubs: output is garbage until ALU_LAT cycles after the alu_start cycle.
    logic [3:0] age1 = 4'd0, age4 = 4'd0;
    always @(posedge clk) begin
        if (alu_start) age1 <= 4'd1;
        else if (age1 != 4'd0 && age1 != 4'd15) age1 <= age1 + 4'd1;
        if (alu_start_l4) age4 <= 4'd1;
        else if (age4 != 4'd0 && age4 != 4'd15) age4 <= age4 + 4'd1;
    end
    always_comb begin
        if (age1 >= 4'(LAT1)) {alu_flags, alu_result} = alu_ref(alu_a, alu_b, alu_op);
        else {alu_flags, alu_result} = {4'hF, 32'hDEADBEEF};
        if (age4 >= 4'(LAT4)) {alu_flags_l4, alu_result_l4} = alu_ref(alu_a_l4, alu_b_l4, alu_op_l4);
        else {alu_flags_l4, alu_result_l4} = {4'hF, 32'hDEADBEEF};
    end

    typedef struct {
        int          edges;
        bit          d0;
        bit          d1;
        logic [31:0] res;
        logic [3:0]  flg;
        bit          excl_bad;
        int          idle_cnt;
        int          start_cnt;
        bit          unstable;
        logic [1:0]  gnt_at_start;
    } obs_t;

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Observes one transaction; edges counts posedges with the first being the one after the call.
    task automatic wait_done(input bit use4, input int drop_at, output obs_t o);
        logic g0, g1, dn0, dn1, st, bz;
        logic [67:0] bus, bus_at_start;
        o.edges = -1; o.d0 = 1'b0; o.d1 = 1'b0; o.res = 32'hx; o.flg = 4'hx;
        o.excl_bad = 1'b0; o.idle_cnt = 0; o.start_cnt = 0; o.unstable = 1'b0; o.gnt_at_start = 2'b00;
        bus_at_start = 68'd0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (use4) begin
                g0 = gnt0_l4; g1 = gnt1_l4; dn0 = done0_l4; dn1 = done1_l4; st = alu_start_l4; bz = busy_l4;
                bus = {alu_a_l4, alu_b_l4, alu_op_l4};
            end else begin
                g0 = gnt0; g1 = gnt1; dn0 = done0; dn1 = done1; st = alu_start; bz = busy;
                bus = {alu_a, alu_b, alu_op};
            end
            if ((g0 && g1) || (dn0 && dn1)) o.excl_bad = 1'b1;
            if (!bz) o.idle_cnt++;
            if (st) begin
                o.start_cnt++; o.gnt_at_start = {g1, g0}; bus_at_start = bus;
            end else if (o.start_cnt > 0 && bus !== bus_at_start) begin
                o.unstable = 1'b1;
            end
            if (k == drop_at) begin
                req0 = 1'b0; a0 = $urandom; b0 = $urandom; op0 = 4'($urandom_range(0, 5));
            end
            if (dn0 || dn1) begin
                o.edges = k; o.d0 = dn0; o.d1 = dn1;
                o.res = use4 ? result_l4 : result;
                o.flg = use4 ? flags_l4 : flags;
                break;
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, done0, done1, alu_start, busy} !== 6'd0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected 000000", {gnt0, gnt1, done0, done1, alu_start, busy});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_op, result, flags} !== 104'd0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", {alu_a, alu_b, alu_op, result, flags});
        end
        n_checks++;
        if ({gnt0_l4, gnt1_l4, done0_l4, done1_l4, alu_start_l4, busy_l4} !== 6'd0) begin
            n_fail++; $display("FAIL reset_ctl_l4: got %b expected 000000",
                               {gnt0_l4, gnt1_l4, done0_l4, done1_l4, alu_start_l4, busy_l4});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single;
        obs_t o;
        do_reset;
        a0 = 32'd5; b0 = 32'd7; op0 = OP_ADD; req0 = 1'b1;
        wait_done(1'b0, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.edges} !== {2'b10, LAT1 + 2}) begin
            n_fail++; $display("FAIL single_done: got d0=%0d d1=%0d edge=%0d expected d0=1 d1=0 edge=%0d",
                               o.d0, o.d1, o.edges, LAT1 + 2);
        end
        n_checks++;
        if ({o.start_cnt, o.gnt_at_start} !== {32'd1, 2'b01}) begin
            n_fail++; $display("FAIL single_start: got starts=%0d gnt=%b expected 1 01", o.start_cnt, o.gnt_at_start);
        end
        n_checks++;
        if ({o.flg, o.res} !== {4'b0000, 32'd12}) begin
            n_fail++; $display("FAIL single_result: got %h/%h expected 0/0000000c", o.flg, o.res);
        end
        req0 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({gnt0, gnt1, busy, done0, done1} !== 5'd0) begin
            n_fail++; $display("FAIL single_release: got %b expected 00000", {gnt0, gnt1, busy, done0, done1});
        end
    endtask

    task automatic test_tie;
        obs_t o;
        do_reset;
        a0 = 32'd5; b0 = 32'd7; op0 = OP_ADD; req0 = 1'b1;
        a1 = 32'd3; b1 = 32'd3; op1 = OP_SUB; req1 = 1'b1;
        wait_done(1'b0, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.res} !== {2'b10, 32'd12}) begin
            n_fail++; $display("FAIL tie_first: got d0=%0d d1=%0d res=%h expected port 0 res=c", o.d0, o.d1, o.res);
        end
        req0 = 1'b0;
        wait_done(1'b0, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.flg, o.res, o.edges} !== {2'b01, 4'b0100, 32'd0, LAT1 + 3}) begin
            n_fail++; $display("FAIL tie_second: got d0=%0d d1=%0d flags=%b res=%h edge=%0d expected port 1 0100 0 %0d",
                               o.d0, o.d1, o.flg, o.res, o.edges, LAT1 + 3);
        end
        req1 = 1'b0;
    endtask

    task automatic test_back_to_back;
        obs_t o;
        bit last, win1;
        do_reset;
        last = 1'b1;
        a0 = 32'd100; b0 = 32'd1; op0 = OP_ADD; req0 = 1'b1;
        a1 = 32'd100; b1 = 32'd1; op1 = OP_SUB; req1 = 1'b1;
        for (int t = 0; t < 6; t++) begin
`ifdef NUCORE_ARB_FIXED_PRIO_EN
            win1 = 1'b0;
`else
            win1 = !last;
`endif
            wait_done(1'b0, 0, o);
            n_checks++;
            if ({o.d0, o.d1, o.res, o.excl_bad} !== {!win1, win1, (win1 ? 32'd99 : 32'd101), 1'b0}) begin
                n_fail++; $display("FAIL b2b_grant[%0d]: got d0=%0d d1=%0d res=%0d excl=%0d expected port %0d",
                                   t, o.d0, o.d1, o.res, o.excl_bad, win1);
            end
            n_checks++;
            if ({o.edges, o.idle_cnt} !== {(t == 0) ? LAT1 + 2 : LAT1 + 3, (t == 0) ? 0 : 1}) begin
                n_fail++; $display("FAIL b2b_timing[%0d]: got edge=%0d idle=%0d expected %0d %0d", t, o.edges,
                                   o.idle_cnt, (t == 0) ? LAT1 + 2 : LAT1 + 3, (t == 0) ? 0 : 1);
            end
            last = win1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_lat4;
        obs_t o;
        do_reset;
        a1 = 32'hFFFF_FFFF; b1 = 32'd1; op1 = OP_ADD; req1 = 1'b1;
        wait_done(1'b1, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.edges} !== {2'b01, LAT4 + 2}) begin
            n_fail++; $display("FAIL lat4_done: got d0=%0d d1=%0d edge=%0d expected 0 1 %0d", o.d0, o.d1, o.edges, LAT4 + 2);
        end
        n_checks++;
        if ({o.flg, o.res} !== {4'b0110, 32'd0}) begin
            n_fail++; $display("FAIL lat4_result: got %b/%h expected 0110/00000000", o.flg, o.res);
        end
        n_checks++;
        if ({o.unstable, o.start_cnt} !== {1'b0, 32'd1}) begin
            n_fail++; $display("FAIL lat4_stable: got unstable=%0d starts=%0d expected 0 1", o.unstable, o.start_cnt);
        end
        req1 = 1'b0;
    endtask

    task automatic test_drop_mid_wait;
        obs_t o;
        do_reset;
        a0 = 32'h1234; b0 = 32'h10; op0 = OP_SUB; req0 = 1'b1;
        wait_done(1'b0, 2, o);
        n_checks++;
        if ({o.d0, o.d1, o.flg, o.res} !== {2'b10, 4'b0000, 32'h1224}) begin
            n_fail++; $display("FAIL drop_result: got d0=%0d d1=%0d %b/%h expected 1 0 0000/00001224",
                               o.d0, o.d1, o.flg, o.res);
        end
    endtask

    task automatic test_async_reset;
        obs_t o;
        do_reset;
        a0 = 32'd9; b0 = 32'd1; op0 = OP_ADD; req0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({gnt0, gnt1, done0, done1, alu_start, busy, alu_a} !== 38'd0) begin
            n_fail++; $display("FAIL async_reset: got %b alu_a=%h expected all 0",
                               {gnt0, gnt1, done0, done1, alu_start, busy}, alu_a);
        end
        n_checks++;
        if ({gnt0_l4, busy_l4, alu_a_l4} !== 34'd0) begin
            n_fail++; $display("FAIL async_reset_l4: got gnt=%0d busy=%0d alu_a=%h expected 0",
                               gnt0_l4, busy_l4, alu_a_l4);
        end
        req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({done0, done1, busy, gnt0} !== 4'd0) begin
            n_fail++; $display("FAIL async_no_resume: got %b expected 0000", {done0, done1, busy, gnt0});
        end
        a0 = 32'd2; b0 = 32'd2; op0 = OP_ADD; req0 = 1'b1;
        a1 = 32'd7; b1 = 32'd7; op1 = OP_SUB; req1 = 1'b1;
        wait_done(1'b0, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.res} !== {2'b10, 32'd4}) begin
            n_fail++; $display("FAIL async_first_tie: got d0=%0d d1=%0d res=%h expected port 0 res=4", o.d0, o.d1, o.res);
        end
        req0 = 1'b0;
        wait_done(1'b0, 0, o);
        n_checks++;
        if ({o.d0, o.d1, o.flg, o.res} !== {2'b01, 4'b0100, 32'd0}) begin
            n_fail++; $display("FAIL async_req1: got d0=%0d d1=%0d %b/%h expected port 1 0100/0", o.d0, o.d1, o.flg, o.res);
        end
        req1 = 1'b0;
    endtask

    task automatic test_random;
        obs_t o;
        bit p0, p1, last, win1, from_done;
        logic [31:0] ea0, eb0, ea1, eb1;
        logic [3:0] eo0, eo1;
        logic [35:0] exp;
        do_reset;
        p0 = 1'b0; p1 = 1'b0; last = 1'b1; from_done = 1'b0;
        ea0 = 32'd0; eb0 = 32'd0; ea1 = 32'd0; eb1 = 32'd0; eo0 = 4'd0; eo1 = 4'd0;
        for (int it = 0; it < 30; it++) begin
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; ea0 = $urandom; eb0 = $urandom; eo0 = 4'($urandom_range(0, 5));
                a0 = ea0; b0 = eb0; op0 = eo0; req0 = 1'b1;
            end
            if (!p1 && ($urandom_range(0, 1) == 1 || !p0)) begin
                p1 = 1'b1; ea1 = $urandom; eb1 = $urandom; eo1 = 4'($urandom_range(0, 5));
                a1 = ea1; b1 = eb1; op1 = eo1; req1 = 1'b1;
            end
`ifdef NUCORE_ARB_FIXED_PRIO_EN
            win1 = !p0;
`else
            win1 = (p0 && p1) ? !last : p1;
`endif
            exp = win1 ? alu_ref(ea1, eb1, eo1) : alu_ref(ea0, eb0, eo0);
            wait_done(1'b0, 0, o);
            n_checks++;
            if ({o.d0, o.d1, o.excl_bad} !== {!win1, win1, 1'b0}) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got d0=%0d d1=%0d excl=%0d expected port %0d",
                                   it, o.d0, o.d1, o.excl_bad, win1);
            end
            n_checks++;
            if ({o.flg, o.res} !== exp) begin
                n_fail++; $display("FAIL rand_result[%0d]: got %h expected %h", it, {o.flg, o.res}, exp);
            end
            n_checks++;
            if (o.edges !== (from_done ? LAT1 + 3 : LAT1 + 2)) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, o.edges,
                                   from_done ? LAT1 + 3 : LAT1 + 2);
            end
            if (win1) begin p1 = 1'b0; req1 = 1'b0; end
            else begin p0 = 1'b0; req0 = 1'b0; end
            last = win1;
            from_done = 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single;
        test_tie;
        test_back_to_back;
        test_lat4;
        test_drop_mid_wait;
        test_async_reset;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
